regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file for the RISC-V core: one write port, NUM_READ_PORTS synchronous read ports, x0 hard-wired to zero, and a counter-driven soft-clear sequencer. It replaces the single-instance 2R1W register file between decode (read addresses) and writeback (write port). A dedicated debug tap exposes one architectural register, a0 by default, to the testbench.

## Interface
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- DATA_W, 32, register data width
- NUM_READ_PORTS, 2, number of read ports, 1..4
- TAP_INDEX, 10, register index driven on tap_data (x10 = a0)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address (rd)
- wdata  in  DATA_W  write data
- raddr  in  NUM_READ_PORTS*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_READ_PORTS*DATA_W  packed registered read data; port i at bits [i*DATA_W +: DATA_W]
- clr_req  in  1  single-cycle pulse requesting a soft clear of all registers
- clr_busy  out  1  high while the clear sequence runs
- tap_data  out  DATA_W  current contents of register TAP_INDEX

## Operation
- Storage: DEPTH x DATA_W flops. Entry 0 is never written and always reads 0.
- Write: on a rising edge with we=1, waddr!=0 and clr_busy=0, entry[waddr] <= wdata. Writes to x0 are discarded. Writes while clr_busy=1 are dropped, not queued.
- Read: every cycle, each port i registers rdata[i] <= entry[raddr[i]]. raddr[i]=0 always yields 0.
- Multiple ports may use the same address; each returns the same value independently.
- FSM states: IDLE and CLEAR.
  - IDLE: clr_busy=0. clr_req=1 moves to CLEAR and loads clr_cnt=1.
  - CLEAR: clr_busy=1. Each cycle entry[clr_cnt] <= 0 and clr_cnt increments. After clearing DEPTH-1, return to IDLE.
  - clr_req while in CLEAR is ignored.
- Reads during CLEAR return current array contents: already-cleared entries read 0, others read their old value.
- tap_data is driven directly from entry[TAP_INDEX]. It is not an extra pipeline stage.

## Timing
- Reset (rst_n=0, asynchronous): all entries 0, all rdata 0, tap_data 0, clr_busy 0, FSM in IDLE, clr_cnt 0. Reset asserted mid-clear aborts the clear immediately.
- Read latency: 1 cycle. raddr sampled at edge N; rdata valid after edge N and held until edge N+1.
- Write visibility: a write at edge N is visible on tap_data after edge N and on any read port sampled at edge N+1 or later.
- Same-edge write/read to the same nonzero address is governed by the configuration macro below.
- Clear duration: clr_req sampled at edge N.
  - clr_busy is high from after edge N through edge N+DEPTH-1, which is 31 cycles for ADDR_W=5.
  - clr_busy drops after edge N+DEPTH-1.
  - The first accepted write is at edge N+DEPTH.
- Writes are blocked during CLEAR, so a write can never collide with a clear on the same edge.

## Configuration
- REGFILE_MP_BYPASS_EN defined:
  - If at edge N we=1, clr_busy=0, waddr!=0 and raddr[i]==waddr, then rdata[i] <= wdata, forwarding the new value.
  - Forwarding is never applied to x0 or while clr_busy=1.
- REGFILE_MP_BYPASS_EN undefined: rdata[i] returns the pre-write contents for that edge. The new value appears on the next read.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: rdata, tap_data and clr_busy all 0. Release rst_n, read all 32 addresses on both ports: all return 0.
- Write/read with x0: write 0xDEADBEEF to x5 and 0x12345678 to x0, then read raddr={x0,x5}. Required: rdata={0, 0xDEADBEEF} one cycle later.
- Tap: write 0xCAFEF00D to x10. Required: tap_data=0xCAFEF00D after that edge; a write to x11 leaves tap_data unchanged.
- Same-cycle collision: x7=0x1, then we=1, waddr=7, wdata=0x2 with raddr[0]=7 on the same edge. Required: rdata[0]=0x2 with REGFILE_MP_BYPASS_EN, 0x1 without; the next read returns 0x2 in both builds.
- Clear: fill x1..x31 with index*0x11 and pulse clr_req.
  - Required: clr_busy high for exactly 31 cycles.
  - A write to x3 issued mid-clear is dropped.
  - A second clr_req during CLEAR is ignored.
  - Afterwards all registers read 0.
- Reset mid-clear: pulse clr_req, then assert rst_n=0 after 10 cycles. Required: clr_busy 0 immediately; FSM in IDLE after release; all entries 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read, clear and tap signals of the multi-port register file
interface regfile_mp_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_READ_PORTS = 2
);
  logic                             we;
  logic [ADDR_W-1:0]                waddr;
  logic [DATA_W-1:0]                wdata;
  logic [NUM_READ_PORTS*ADDR_W-1:0] raddr;
  logic [NUM_READ_PORTS*DATA_W-1:0] rdata;
  logic                             clr_req;
  logic                             clr_busy;
  logic [DATA_W-1:0]                tap_data;
  modport master (output we, waddr, wdata, raddr, clr_req, input rdata, clr_busy, tap_data);
  modport slave  (input we, waddr, wdata, raddr, clr_req, output rdata, clr_busy, tap_data);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 1W/NR register file, x0 = 0, soft-clear sequencer; REGFILE_MP_BYPASS_EN enables write-to-read forwarding
module regfile_mp #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int TAP_INDEX = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_READ_PORTS*DATA_W-1:0] rd_nxt;
  logic wr_ok;
  assign wr_ok = bus.we && bus.waddr != '0 && state == IDLE;
  assign bus.clr_busy = state == CLEAR;
  assign bus.tap_data = mem[ADDR_W'(TAP_INDEX)];
  always_comb begin
    state_nxt = state;
    if (state == IDLE && bus.clr_req) state_nxt = CLEAR;
    if (state == CLEAR && &clr_cnt) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= state == IDLE ? (bus.clr_req ? ADDR_W'(1) : clr_cnt) : clr_cnt + 1'b1;
    end
  // entry 0 is only ever reset, so it reads 0 without a special case
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end else if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
`ifdef REGFILE_MP_BYPASS_EN
      rd_nxt[i*DATA_W +: DATA_W] = (wr_ok && bus.raddr[i*ADDR_W +: ADDR_W] == bus.waddr)
                                 ? bus.wdata : mem[bus.raddr[i*ADDR_W +: ADDR_W]];
`else
      rd_nxt[i*DATA_W +: DATA_W] = mem[bus.raddr[i*ADDR_W +: ADDR_W]];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.rdata <= '0;
    else        bus.rdata <= rd_nxt;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scoreboard bench for regfile_mp (2 read ports, 32 x 32-bit)
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  regfile_mp_if #(.ADDR_W(5), .DATA_W(32), .NUM_READ_PORTS(2)) bus ();
  regfile_mp #(.ADDR_W(5), .DATA_W(32), .NUM_READ_PORTS(2), .TAP_INDEX(10)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] model [32];
  logic        busy_m = 1'b0;
  logic [4:0]  cnt_m = '0;
  logic [31:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: predict reads and state from the model, clock, compare
  task automatic tick();
    logic [4:0]  a;
    logic [31:0] e;
    for (int p = 0; p < 2; p++) begin
      a = bus.raddr[p*5 +: 5];
      e = model[a];
`ifdef REGFILE_MP_BYPASS_EN
      if (bus.we && bus.waddr != 0 && !busy_m && a == bus.waddr) e = bus.wdata;
`endif
      sb.push_back(e);
    end
    if (busy_m) begin
      model[cnt_m] = '0;
      if (cnt_m == 5'd31) busy_m = 1'b0;
      cnt_m = cnt_m + 1'b1;
    end else begin
      if (bus.we && bus.waddr != 0) model[bus.waddr] = bus.wdata;
      if (bus.clr_req) begin busy_m = 1'b1; cnt_m = 5'd1; end
    end
    @(posedge clk); #1;
    for (int p = 0; p < 2; p++) chk($sformatf("rdata%0d", p), 64'(bus.rdata[p*32 +: 32]), 64'(sb.pop_front()));
    chk("tap", 64'(bus.tap_data), 64'(model[10]));
    chk("busy", 64'(bus.clr_busy), 64'(busy_m));
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int k = 0; k < 4; k++) begin
      bus.we = 1'($urandom); bus.waddr = 5'($urandom); bus.wdata = $urandom;
      bus.raddr = 10'($urandom); bus.clr_req = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_rdata", 64'(bus.rdata), 64'd0);
      chk("rst_tap", 64'(bus.tap_data), 64'd0);
      chk("rst_busy", 64'(bus.clr_busy), 64'd0);
    end
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0; bus.clr_req = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(a), 5'(31 - a)};
      tick();
      chk("post_rst_read", 64'(bus.rdata), 64'd0);
    end

    wr(5'd5, 32'hDEADBEEF);
    wr(5'd0, 32'h12345678);
    bus.raddr = {5'd0, 5'd5};
    tick();
    chk("x0_x5", 64'(bus.rdata), 64'h00000000_DEADBEEF);

    wr(5'd10, 32'hCAFEF00D);
    chk("tap_write", 64'(bus.tap_data), 64'hCAFEF00D);
    wr(5'd11, 32'h55555555);
    chk("tap_hold", 64'(bus.tap_data), 64'hCAFEF00D);

    wr(5'd7, 32'h1);
    bus.raddr = {5'd7, 5'd7};
    wr(5'd7, 32'h2);
`ifdef REGFILE_MP_BYPASS_EN
    chk("collide", 64'(bus.rdata[31:0]), 64'h2);
`else
    chk("collide", 64'(bus.rdata[31:0]), 64'h1);
`endif
    tick();
    chk("collide_next", 64'(bus.rdata), 64'h00000002_00000002);

    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i * 32'h11));
    bus.raddr = {5'd31, 5'd3};
    tick();
    chk("fill", 64'(bus.rdata), {32'(31 * 32'h11), 32'h33});
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      bus.raddr = 10'($urandom);
      bus.we = (n == 5); bus.waddr = 5'd3; bus.wdata = 32'hBAD0BAD0;
      bus.clr_req = (n == 8);
      tick();
    end
    bus.we = 1'b0; bus.clr_req = 1'b0;
    chk("clr_cycles", 64'(n), 64'd31);
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(a), 5'(a)};
      tick();
      chk("post_clr_read", 64'(bus.rdata), 64'd0);
    end
    chk("post_clr_busy", 64'(bus.clr_busy), 64'd0);

    wr(5'd10, 32'hA5A5A5A5);
    wr(5'd20, 32'h5A5A5A5A);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (10) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.clr_busy), 64'd0);
    chk("midrst_tap", 64'(bus.tap_data), 64'd0);
    chk("midrst_rdata", 64'(bus.rdata), 64'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    busy_m = 1'b0; cnt_m = '0; sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bus.raddr = {5'(a), 5'(a)};
      tick();
      chk("midrst_read", 64'(bus.rdata), 64'd0);
    end
    wr(5'd3, 32'h77);
    chk("idle_after_rst", 64'(bus.clr_busy), 64'd0);
    bus.raddr = {5'd3, 5'd0};
    tick();
    chk("write_after_rst", 64'(bus.rdata), 64'h00000077_00000000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
